hazard_forward_ctrl: RTL
========================

// Module: hazard_forward_ctrl
// PURPOSE
//  Pipeline hazard/forwarding controller for the 5-stage ARM core. Keeps shadow copies of dest/WB/load
//  info for the EXE, MEM and WB stages; drives the EXE-stage operand-mux selects (Sel_src1/Sel_src2)
//  and the ID-stage stall (hazard). Sits beside ID/EXE pipeline registers; honours freeze (memory busy)
//  and flush (branch taken). Counts stall cycles for performance monitoring.
// PARAMETERS
//  REG_W  4   register-index width
//  CNT_W  16  stall-counter width (saturating)
// PORTS
//  clk            in   1      clock, rising edge
//  rst            in   1      synchronous reset, active-high
//  forward_en     in   1      1 = forwarding on; 0 = stall on every RAW dependency
//  freeze         in   1      1 = whole pipeline held this cycle (memory wait)
//  flush          in   1      1 = branch taken; instruction in ID is killed
//  ID_valid       in   1      ID holds a real instruction
//  ID_src1        in   REG_W  first source (Rn)
//  ID_src1_used   in   1      instruction reads src1
//  ID_src2        in   REG_W  second source (Rm, or Rd for STR)
//  ID_two_src     in   1      instruction reads src2
//  ID_dest        in   REG_W  destination register
//  ID_WB_EN       in   1      instruction writes register file
//  ID_MEM_R_EN    in   1      instruction is a load
//  hazard         out  1      stall IF/ID, insert bubble into EXE (combinational)
//  Sel_src1       out  2      EXE Val1 mux select: 00 regfile, 01 ALU_Res_Frwrd (MEM), 10 WB_Value_Frwrd
//  Sel_src2       out  2      EXE Val_Rm mux select, same encoding; 11 never driven
//  stall_count    out  CNT_W  stall cycles since reset
// BEHAVIOUR
//  State: EXE slot {v,src1,s1u,src2,s2u,dest,wb,ld}; MEM slot {dest,wb}; WB slot {dest,wb}; counter.
//  Reset: all slot wb/ld/s1u/s2u/v = 0, dests/srcs = 0, stall_count = 0; outputs then hazard=0, Sel=00.
//  Advance (freeze=0, rising edge): WB<=MEM; MEM<=EXE{dest,wb}; EXE<=ID fields if ID_valid & !hazard
//   & !flush, else EXE<=bubble (v,wb,ld,s1u,s2u = 0). freeze=1: every slot holds, counter holds.
//  Match(x,slot) = slot.wb & (x == slot.dest); src1 counts only if ID_src1_used, src2 only if ID_two_src.
//  hazard (ID_valid & !flush required, else 0):
//   forward_en=1: Match(ID src, EXE) & EXE.ld  (load-use, exactly one bubble).
//   forward_en=0: Match(ID src, EXE) | Match(ID src, MEM). WB stage never stalls (regfile writes on
//   negedge, read-after-write in same cycle returns new value).
//  Sel_srcN (combinational from registered state, zero latency; 00 if forward_en=0 or !EXE.sNu):
//   Match(EXE.srcN, MEM) -> 01; else Match(EXE.srcN, WB) -> 10; else 00. MEM has priority over WB.
//  Loads in MEM never forwarded via 01: load-use bubble guarantees data arrives from WB (10).
//  stall_count: +1 on each edge with freeze=0 & hazard=1; saturates at 2^CNT_W-1, no wrap.
//  Simultaneous: flush & hazard -> flush wins (hazard=0, bubble). freeze & hazard -> hazard stays high,
//   nothing advances, no count. rst overrides freeze/flush; reset mid-stall clears slots -> hazard drops
//   next cycle.
//  R15/PC reads not tracked here; ID decode clears srcN_used for PC-relative operands.
// TESTING
//  1 fwd_en=1: ADD R1 then SUB R2,R1,R3 back-to-back -> no hazard; SUB in EXE sees Sel_src1=01, Sel_src2=00.
//  2 fwd_en=1: ADD R1; NOP; ORR R4,R5,R1 -> ORR in EXE: Sel_src2=10, hazard never asserted.
//  3 fwd_en=1: LDR R2,[R0]; ADD R3,R2,R2 -> hazard=1 one cycle, stall_count=1; next cycle Sel_src1=Sel_src2=10.
//  4 fwd_en=0: MOV R6 then CMP R6,R7 -> hazard 2 cycles, Sel stays 00, stall_count=2.
//  5 load-use with freeze=1 for 3 cycles -> hazard held, slots frozen, stall_count unchanged, then +1.
//  6 hazard cycle with flush=1 -> hazard=0, EXE bubble; rst during stall -> stall_count=0, Sel=00.

Source files
------------

// File: rtl/hazard_forward_ctrl.sv
// Hazard detection and EXE operand forwarding control for the 5-stage core.
// Tracks EXE/MEM/WB destination shadows, drives mux selects, ID stall and a stall counter.
module hazard_forward_ctrl #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             forward_en,
  input  logic             freeze,
  input  logic             flush,
  input  logic             ID_valid,
  input  logic [REG_W-1:0] ID_src1,
  input  logic             ID_src1_used,
  input  logic [REG_W-1:0] ID_src2,
  input  logic             ID_two_src,
  input  logic [REG_W-1:0] ID_dest,
  input  logic             ID_WB_EN,
  input  logic             ID_MEM_R_EN,
  output logic             hazard,
  output logic [1:0]       Sel_src1,
  output logic [1:0]       Sel_src2,
  output logic [CNT_W-1:0] stall_count
);

  logic             exe_v;
  logic [REG_W-1:0] exe_src1;
  logic             exe_s1u;
  logic [REG_W-1:0] exe_src2;
  logic             exe_s2u;
  logic [REG_W-1:0] exe_dest;
  logic             exe_wb;
  logic             exe_ld;

  logic [REG_W-1:0] mem_dest;
  logic             mem_wb;
  logic [REG_W-1:0] wb_dest;
  logic             wb_wb;

  logic id_s1_exe;
  logic id_s2_exe;
  logic id_s1_mem;
  logic id_s2_mem;
  logic dep_exe;
  logic dep_mem;
  logic issue;
  logic cnt_max;

  assign id_s1_exe = ID_src1_used & exe_wb & (ID_src1 == exe_dest);
  assign id_s2_exe = ID_two_src & exe_wb & (ID_src2 == exe_dest);
  assign id_s1_mem = ID_src1_used & mem_wb & (ID_src1 == mem_dest);
  assign id_s2_mem = ID_two_src & mem_wb & (ID_src2 == mem_dest);
  assign dep_exe   = id_s1_exe | id_s2_exe;
  assign dep_mem   = id_s1_mem | id_s2_mem;

  // With forwarding only a load in EXE can't be bypassed; without it
  // anything in EXE or MEM stalls. WB is covered by the split-cycle regfile.
  always_comb begin
    hazard = 1'b0;
    if (ID_valid && !flush) begin
      if (forward_en) hazard = dep_exe & exe_ld;
      else            hazard = dep_exe | dep_mem;
    end
  end

  always_comb begin
    Sel_src1 = 2'b00;
    if (forward_en && exe_s1u) begin
      if (mem_wb && (exe_src1 == mem_dest))     Sel_src1 = 2'b01;
      else if (wb_wb && (exe_src1 == wb_dest))  Sel_src1 = 2'b10;
    end
  end

  always_comb begin
    Sel_src2 = 2'b00;
    if (forward_en && exe_s2u) begin
      if (mem_wb && (exe_src2 == mem_dest))     Sel_src2 = 2'b01;
      else if (wb_wb && (exe_src2 == wb_dest))  Sel_src2 = 2'b10;
    end
  end

  assign issue   = ID_valid & ~hazard & ~flush;
  assign cnt_max = &stall_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_v       <= 1'b0;
      exe_src1    <= '0;
      exe_s1u     <= 1'b0;
      exe_src2    <= '0;
      exe_s2u     <= 1'b0;
      exe_dest    <= '0;
      exe_wb      <= 1'b0;
      exe_ld      <= 1'b0;
      mem_dest    <= '0;
      mem_wb      <= 1'b0;
      wb_dest     <= '0;
      wb_wb       <= 1'b0;
      stall_count <= '0;
    end else if (!freeze) begin
      wb_dest  <= mem_dest;
      wb_wb    <= mem_wb;
      mem_dest <= exe_dest;
      mem_wb   <= exe_wb;
      if (issue) begin
        exe_v    <= 1'b1;
        exe_src1 <= ID_src1;
        exe_s1u  <= ID_src1_used;
        exe_src2 <= ID_src2;
        exe_s2u  <= ID_two_src;
        exe_dest <= ID_dest;
        exe_wb   <= ID_WB_EN;
        exe_ld   <= ID_MEM_R_EN;
      end else begin
        exe_v    <= 1'b0;
        exe_s1u  <= 1'b0;
        exe_s2u  <= 1'b0;
        exe_wb   <= 1'b0;
        exe_ld   <= 1'b0;
      end
      if (hazard && !cnt_max)
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule
